// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed 7-segment driver for a BCD decade-counter chain.
// A prescaler sets how long each digit is lit; new data is double-buffered
// and only becomes visible at a frame boundary so a frame never shows a mix
// of old and new digits. Optional leading-zero blanking; digits above 9
// show a dash and raise bcd_err.
module bcd_scan_driver #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        bcd_err
);

  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] active_q, active_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        fd_q, fd_d;
  logic        lz_q;

  logic        tick;
  logic        boundary;
  logic [3:0]  digit;
  logic [6:0]  seg_dec;
  logic [3:0]  nz;
  logic [3:0]  blank;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 2'd3);

  // Next-state logic: prescaler, digit scan, double-buffered data capture.
  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    fd_d      = boundary;

    if (tick) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end

    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end

    // At the frame boundary a coincident load wins over the stored shadow.
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        active_d = bcd_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 16'd0;
      idx_q     <= 2'd0;
      active_q  <= 16'd0;
      shadow_q  <= 16'd0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      lz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      lz_q      <= lz_blank;
    end
  end

  // Blank digit k only when it and every more-significant digit are zero;
  // digit 0 always stays lit so a zero value still shows "0".
  for (genvar gi = 0; gi < 4; gi++) begin : g_blank
    assign nz[gi] = |active_q[gi*4 +: 4];
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = lz_q & ~(|nz[3:gi]);
    end
  end

  assign digit = active_q[{idx_q, 2'b00} +: 4];

  // Segment decode {g,f,e,d,c,b,a}; out-of-range values render as a dash.
  always_comb begin
    seg_dec = 7'h40;
    case (digit)
      4'd0: seg_dec = 7'h3F;
      4'd1: seg_dec = 7'h06;
      4'd2: seg_dec = 7'h5B;
      4'd3: seg_dec = 7'h4F;
      4'd4: seg_dec = 7'h66;
      4'd5: seg_dec = 7'h6D;
      4'd6: seg_dec = 7'h7D;
      4'd7: seg_dec = 7'h07;
      4'd8: seg_dec = 7'h7F;
      4'd9: seg_dec = 7'h6F;
      default: seg_dec = 7'h40;
    endcase
  end

  assign seg        = blank[idx_q] ? 7'h00 : seg_dec;
  assign an         = 4'b0001 << idx_q;
  assign bcd_err    = (digit > 4'd9);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with PRESCALE=4 (16-cycle frames).
// A table of loaded values with hand-decoded segment patterns is walked
// frame by frame, followed by hand-written sequences for double loads,
// a load coincident with the frame boundary, and a mid-frame reset.
module tb_bcd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        bcd_err;

  bcd_scan_driver #(.PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     v;
    logic            lz;
    logic [3:0][6:0] s;    // s[k] = expected seg for digit k
    logic [3:0]      e;    // e[k] = expected bcd_err for digit k
  } vec_t;

  vec_t tbl [10];

  int checks = 0;
  int errors = 0;
  int t      = 0;          // rising edges since reset release

  logic [3:0][6:0] exp_seg;
  logic [3:0]      exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  // Compare outputs for frame position c (0..15) at the current cycle.
  task automatic check_cycle(input int c);
    int d;
    d = c / 4;
    chk("an", 32'(an), 32'(4'b0001 << d));
    chk("seg", 32'(seg), 32'(exp_seg[d]));
    chk("bcd_err", 32'(bcd_err), 32'(exp_err[d]));
    chk("frame_done", 32'(frame_done), 32'((c == 0) && (t != 0)));
  endtask

  // Check one whole frame, optionally issuing loads at frame positions
  // la/lb (-1 for none); lz_blank is updated just before the boundary edge.
  task automatic run_frame(input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb,
                           input logic nlz);
    $display("frame t=%0d expect seg %h %h %h %h err %b load@%0d=%h load@%0d=%h",
             t, exp_seg[3], exp_seg[2], exp_seg[1], exp_seg[0], exp_err, la, va, lb, vb);
    for (int c = 0; c < 16; c++) begin
      check_cycle(c);
      load   = (c == la) || (c == lb);
      bcd_in = (c == lb) ? vb : va;
      if (c == 15) lz_blank = nlz;
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
    tbl[1] = '{16'h0090, 1'b1, {7'h00, 7'h00, 7'h6F, 7'h3F}, 4'b0000};
    tbl[2] = '{16'h0090, 1'b0, {7'h3F, 7'h3F, 7'h6F, 7'h3F}, 4'b0000};
    tbl[3] = '{16'h00A5, 1'b0, {7'h3F, 7'h3F, 7'h40, 7'h6D}, 4'b0010};
    tbl[4] = '{16'h00A5, 1'b1, {7'h00, 7'h00, 7'h40, 7'h6D}, 4'b0010};
    tbl[5] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
    tbl[6] = '{16'h5678, 1'b0, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0000};
    tbl[7] = '{16'h0F09, 1'b1, {7'h00, 7'h40, 7'h3F, 7'h6F}, 4'b0100};
    tbl[8] = '{16'h9000, 1'b1, {7'h6F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000};
    tbl[9] = '{16'hBCDE, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};

    rst      = 1'b0;
    load     = 1'b0;
    bcd_in   = 16'h0000;
    lz_blank = 1'b0;
    #1 rst = 1'b1;
    #1;
    $display("reset asserted");
    chk("reset_seg", 32'(seg), 32'h3F);
    chk("reset_an", 32'(an), 32'h1);
    chk("reset_err", 32'(bcd_err), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_seg", 32'(seg), 32'h3F);
    chk("reset_hold_an", 32'(an), 32'h1);
    rst = 1'b0;
    t   = 0;

    // Active register is zero after reset: every digit shows "0".
    exp_seg = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    exp_err = 4'b0000;

    // Each frame checks the previously loaded vector while loading the next.
    for (int i = 0; i < 10; i++) begin
      run_frame(3, tbl[i].v, -1, 16'h0000, tbl[i].lz);
      exp_seg = tbl[i].s;
      exp_err = tbl[i].e;
    end

    // Two loads in one frame: current frame untouched, the later one wins.
    run_frame(2, 16'h0007, 6, 16'h0009, 1'b0);
    exp_seg = {7'h3F, 7'h3F, 7'h3F, 7'h6F};
    exp_err = 4'b0000;

    // Load on the boundary tick itself; shows from digit 0 of the next frame.
    run_frame(15, 16'h0042, -1, 16'h0000, 1'b1);
    exp_seg = {7'h00, 7'h00, 7'h66, 7'h5B};
    exp_err = 4'b0000;

    // Mid-frame reset while digit 2 is lit and a load is pending.
    $display("partial frame t=%0d load 8888 then reset at digit 2", t);
    for (int c = 0; c < 9; c++) begin
      check_cycle(c);
      load   = (c == 1);
      bcd_in = 16'h8888;
      step();
    end
    load = 1'b0;
    check_cycle(9);
    rst = 1'b1;
    #1;
    chk("midrst_seg", 32'(seg), 32'h3F);
    chk("midrst_an", 32'(an), 32'h1);
    chk("midrst_err", 32'(bcd_err), 32'h0);
    chk("midrst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    lz_blank = 1'b0;
    rst      = 1'b0;
    t        = 0;
    exp_seg  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    exp_err  = 4'b0000;
    // The discarded shadow (8888) must never appear.
    run_frame(-1, 16'h0000, -1, 16'h0000, 1'b0);
    run_frame(-1, 16'h0000, -1, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
